// File: rtl/mac_tx_frame_gen.sv
// mac_tx_frame_gen: counting-payload Ethernet test-frame source for mac_rgmii TX.
// Define MAC_TX_GEN_FCS_EN to append a hardware CRC-32 FCS to every frame.
module mac_tx_frame_gen #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1500
) (
  input  logic        mac_tx_clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [15:0] frame_num_i,
  input  logic [10:0] len_i,
  input  logic [47:0] dst_mac_i,
  input  logic [47:0] src_mac_i,
  input  logic [15:0] eth_type_i,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_valid,
  output logic        mac_tx_sof,
  output logic        mac_tx_eof,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] frame_cnt_o
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_PAY,
`ifdef MAC_TX_GEN_FCS_EN
    S_FCS,
`endif
    S_IFG
  } state_t;

  localparam logic [10:0] LMIN     = 11'd46;
  localparam logic [10:0] LMAX     = 11'(MAX_LEN);
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

  state_t       r_state;
  state_t       w_state_n;
  logic [10:0]  r_cnt;
  logic [10:0]  w_cnt_n;
  logic [10:0]  r_len;
  logic [10:0]  w_len;
  logic [111:0] r_hdr;
  logic [111:0] w_hdr;
  logic [15:0]  r_run;
  logic         r_inf;
  logic [31:0]  r_frame_cnt;
  logic [7:0]   r_data;
  logic         r_valid;
  logic         r_sof;
  logic         r_eof;
  logic         r_done;
  logic [7:0]   w_data;
  logic         w_valid;
  logic         w_start;
  logic         w_eof;
  logic         w_done;

`ifdef MAC_TX_GEN_FCS_EN
  logic [31:0] r_crc;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction
`endif

  assign w_len = (len_i < LMIN) ? LMIN :
                 (len_i > LMAX) ? LMAX : len_i;

  // First header byte comes straight from the inputs being latched.
  assign w_hdr = (r_state == S_HDR) ? r_hdr :
                 {dst_mac_i, src_mac_i, eth_type_i};

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 11'd1;
    w_start   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (enable_i) begin
          w_state_n = S_HDR;
          w_start   = 1'b1;
        end
      end
      S_HDR: if (r_cnt == 11'd13) begin
        w_state_n = S_SEQ;
        w_cnt_n   = '0;
      end
      S_SEQ: if (r_cnt == 11'd3) begin
        w_state_n = S_PAY;
        w_cnt_n   = 11'd4;
      end
      S_PAY: if (r_cnt == r_len - 11'd1) begin
`ifdef MAC_TX_GEN_FCS_EN
        w_state_n = S_FCS;
`else
        w_state_n = S_IFG;
`endif
        w_cnt_n   = '0;
      end
`ifdef MAC_TX_GEN_FCS_EN
      S_FCS: if (r_cnt == 11'd3) begin
        w_state_n = S_IFG;
        w_cnt_n   = '0;
      end
`endif
      S_IFG: if (r_cnt == IFG_LAST) begin
        w_cnt_n = '0;
        if (!enable_i || (!r_inf && r_run == 16'd0)) begin
          w_state_n = S_IDLE;
          w_done    = 1'b1;
        end else begin
          w_state_n = S_HDR;
          w_start   = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase

    w_data  = 8'h00;
    w_valid = 1'b0;
    w_eof   = 1'b0;
    case (w_state_n)
      S_HDR: begin
        w_valid = 1'b1;
        for (int i = 0; i < 14; i++)
          if (w_cnt_n[3:0] == 4'(i))
            w_data = w_hdr[111-8*i -: 8];
      end
      S_SEQ: begin
        w_valid = 1'b1;
        case (w_cnt_n[1:0])
          2'd0:    w_data = r_frame_cnt[31:24];
          2'd1:    w_data = r_frame_cnt[23:16];
          2'd2:    w_data = r_frame_cnt[15:8];
          default: w_data = r_frame_cnt[7:0];
        endcase
      end
      S_PAY: begin
        w_valid = 1'b1;
        w_data  = w_cnt_n[7:0];
`ifndef MAC_TX_GEN_FCS_EN
        w_eof   = (w_cnt_n == r_len - 11'd1);
`endif
      end
`ifdef MAC_TX_GEN_FCS_EN
      S_FCS: begin
        w_valid = 1'b1;
        w_eof   = (w_cnt_n == 11'd3);
        case (w_cnt_n[1:0])
          2'd0:    w_data = ~r_crc[7:0];
          2'd1:    w_data = ~r_crc[15:8];
          2'd2:    w_data = ~r_crc[23:16];
          default: w_data = ~r_crc[31:24];
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge mac_tx_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= LMIN;
      r_hdr       <= '0;
      r_run       <= '0;
      r_inf       <= 1'b0;
      r_frame_cnt <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_sof   <= w_start;
      r_eof   <= w_eof;
      r_done  <= w_done;
      if (w_start) begin
        r_len <= w_len;
        r_hdr <= {dst_mac_i, src_mac_i, eth_type_i};
      end
      if (w_start && r_state == S_IDLE) begin
        r_run <= frame_num_i;
        r_inf <= (frame_num_i == 16'd0);
      end else if (w_eof && !r_inf) begin
        r_run <= r_run - 16'd1;
      end
      if (w_eof)
        r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

`ifdef MAC_TX_GEN_FCS_EN
  // CRC tracks each data byte as it is registered; held during FCS.
  always_ff @(posedge mac_tx_clk) begin
    if (rst)
      r_crc <= 32'hFFFF_FFFF;
    else if (w_state_n == S_HDR || w_state_n == S_SEQ ||
             w_state_n == S_PAY)
      r_crc <= crc_byte(w_start ? 32'hFFFF_FFFF : r_crc, w_data);
  end
`endif

  assign mac_tx_data  = r_data;
  assign mac_tx_valid = r_valid;
  assign mac_tx_sof   = r_sof;
  assign mac_tx_eof   = r_eof;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_mac_tx_frame_gen.sv
// tb_mac_tx_frame_gen: directed frame-level checks for mac_tx_frame_gen.
// Frames are captured on the falling edge and compared against a byte model.
module tb_mac_tx_frame_gen;
  localparam int IFG = 12;
`ifdef MAC_TX_GEN_FCS_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] fnum;
  logic [10:0] len;
  logic [47:0] da;
  logic [47:0] sa;
  logic [15:0] et;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_valid;
  logic        mac_tx_sof;
  logic        mac_tx_eof;
  logic        busy_o;
  logic        done_o;
  logic [31:0] frame_cnt_o;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] fb [0:2047];

  always #5 clk = ~clk;

  mac_tx_frame_gen #(.IFG_CYCLES(IFG), .MAX_LEN(1500)) u_dut (
    .mac_tx_clk   (clk),
    .rst          (rst),
    .enable_i     (en),
    .frame_num_i  (fnum),
    .len_i        (len),
    .dst_mac_i    (da),
    .src_mac_i    (sa),
    .eth_type_i   (et),
    .mac_tx_data  (mac_tx_data),
    .mac_tx_valid (mac_tx_valid),
    .mac_tx_sof   (mac_tx_sof),
    .mac_tx_eof   (mac_tx_eof),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_b(input logic [31:0] c,
                                        input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] exp_b(input int i, input logic [31:0] seq,
                                       input logic [47:0] d,
                                       input logic [47:0] s,
                                       input logic [15:0] t);
    logic [111:0] h;
    int k;
    h = {d, s, t};
    if (i < 14) return h[111-8*i -: 8];
    if (i < 18) return seq[31-8*(i-14) -: 8];
    k = i - 14;
    return k[7:0];
  endfunction

  task automatic cmp_frame(input string tag, input int n, input int l,
                           input logic [31:0] seq, input logic [47:0] d,
                           input logic [47:0] s, input logic [15:0] t);
    int bad;
    logic [31:0] c;
    logic [7:0] e;
    bad = 0;
    c = 32'hFFFF_FFFF;
    chk({tag, "_len"}, 64'(n), 64'(14 + l + FCS));
    for (int i = 0; i < 14 + l; i++) begin
      e = exp_b(i, seq, d, s, t);
      c = crc_b(c, e);
      if (fb[i] !== e) bad++;
    end
`ifdef MAC_TX_GEN_FCS_EN
    begin
      logic [31:0] f;
      logic [31:0] r;
      logic [31:0] rv;
      f = ~c;
      for (int j = 0; j < 4; j++)
        if (fb[14+l+j] !== f[8*j +: 8]) bad++;
      r = 32'hFFFF_FFFF;
      for (int i = 0; i < n && i < 2048; i++) r = crc_b(r, fb[i]);
      for (int i = 0; i < 32; i++) rv[i] = r[31-i];
      chk({tag, "_residue"}, rv, 32'hC704_DD7B);
    end
`endif
    chk({tag, "_bytes"}, 64'(bad), 0);
  endtask

  task automatic get_frame(input int drop_at, output int n, output int w);
    bit gap;
    gap = 0;
    n = 0;
    w = 0;
    while (!(mac_tx_valid && mac_tx_sof) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      chk("sof_wait", 64'(w), 0);
      return;
    end
    while (n < 2000) begin
      if (!mac_tx_valid || (n > 0 && mac_tx_sof)) gap = 1;
      fb[n] = mac_tx_data;
      n++;
      if (n == drop_at) begin
        en = 1'b0;
        da = 48'h0;
        len = 11'd700;
      end
      if (mac_tx_eof) break;
      @(negedge clk);
    end
    chk("no_gap", 64'(gap), 0);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("done_wait", 64'(k), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_en();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    int k;
    int cnt;
    logic [47:0] da0;
    rst  = 1'b1;
    en   = 1'b0;
    fnum = 16'd1;
    len  = 11'd46;
    da   = 48'hFFFF_FFFF_FFFF;
    sa   = 48'h000A_3501_0203;
    et   = 16'h0800;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(mac_tx_valid), 0);
    chk("rst_data", 64'(mac_tx_data), 0);
    chk("rst_sof", 64'(mac_tx_sof), 0);
    chk("rst_eof", 64'(mac_tx_eof), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_cnt", 64'(frame_cnt_o), 0);

    en = 1'b1;
    @(negedge clk);
    chk("sof_latency", 64'(mac_tx_sof), 1);
    en = 1'b0;
    get_frame(-1, n, w);
    cmp_frame("min", n, 46, 0, da, sa, et);
    chk("min_byte0", 64'(fb[0]), 64'hFF);
    chk("min_byte18", 64'(fb[18]), 64'h04);
    wait_done(k);
    chk("done_latency", 64'(k), 64'(IFG + 1));
    chk("min_cnt", 64'(frame_cnt_o), 1);
    chk("min_idle", 64'(busy_o), 0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o), 0);

    len = 11'd10;
    da  = 48'h0211_2233_4455;
    et  = 16'h88B5;
    pulse_en();
    get_frame(-1, n, w);
    cmp_frame("clamp_lo", n, 46, 1, da, sa, et);
    wait_done(k);

    len = 11'd2000;
    pulse_en();
    get_frame(-1, n, w);
    cmp_frame("clamp_hi", n, 1500, 2, da, sa, et);
    chk("pay_pre_wrap", 64'(fb[269]), 64'hFF);
    chk("pay_wrap", 64'(fb[270]), 64'h00);
    wait_done(k);
    chk("clamp_cnt", 64'(frame_cnt_o), 3);

    do_reset();
    chk("reset_cnt", 64'(frame_cnt_o), 0);
    fnum = 16'd0;
    len  = 11'd60;
    en   = 1'b1;
    for (int f = 0; f < 5; f++) begin
      get_frame(-1, n, w);
      if (f > 0) chk("ifg_gap", 64'(w - 1), 64'(IFG));
      cmp_frame("cont", n, 60, 32'(f), da, sa, et);
    end
    en = 1'b0;
    wait_done(k);
    chk("cont_cnt", 64'(frame_cnt_o), 5);

    do_reset();
    len = 11'd46;
    da0 = da;
    en  = 1'b1;
    get_frame(20, n, w);
    cmp_frame("drop", n, 46, 0, da0, sa, et);
    wait_done(k);
    chk("drop_done_lat", 64'(k), 64'(IFG + 1));
    chk("drop_cnt", 64'(frame_cnt_o), 1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || mac_tx_valid) cnt++;
    end
    chk("drop_no_restart", 64'(cnt), 0);
    da  = da0;
    len = 11'd46;

    fnum = 16'd1;
    pulse_en();
    cnt = 0;
    repeat (30) begin
      if (mac_tx_eof) cnt++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 64'(mac_tx_valid), 0);
    chk("midrst_eof", 64'(mac_tx_eof), 0);
    chk("midrst_data", 64'(mac_tx_data), 0);
    chk("midrst_busy", 64'(busy_o), 0);
    chk("midrst_cnt", 64'(frame_cnt_o), 0);
    chk("midrst_no_eof", 64'(cnt), 0);
    @(negedge clk);
    pulse_en();
    get_frame(-1, n, w);
    cmp_frame("after_rst", n, 46, 0, da, sa, et);
    wait_done(k);
    chk("after_rst_cnt", 64'(frame_cnt_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
